// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if
// Command-side bundle between a client and the PS/2 host transmitter.
//
// Handshake: wr_ps2 is the valid and tx_idle is the ready. A command byte is
// taken on a clk edge where wr_ps2=1 and tx_idle=1; din must hold the byte in
// that same cycle. wr_ps2 while tx_idle=0 is dropped, not queued.
//
// Signals:
//   wr_ps2       client -> tx  start strobe (valid)
//   din[7:0]     client -> tx  command byte
//   tx_idle      tx -> client  no transfer active (ready)
//   tx_done_tick tx -> client  one-cycle pulse, byte sent and ACK=0 seen
//   tx_err       tx -> client  one-cycle pulse, NACK or watchdog timeout
//   state_dbg    tx -> client  current FSM state, for observation only
interface ps2_host_tx_if;
    logic       wr_ps2;
    logic [7:0] din;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       tx_err;
    logic [2:0] state_dbg;

    modport master (
        output wr_ps2, din,
        input  tx_idle, tx_done_tick, tx_err, state_dbg
    );

    modport slave (
        input  wr_ps2, din,
        output tx_idle, tx_done_tick, tx_err, state_dbg
    );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// Host-to-device PS/2 transmitter. Performs the request-to-send sequence,
// shifts a command byte plus odd parity out on device-generated clock falls,
// releases data for the stop bit, samples the device ACK and waits for the
// bus to go idle. A watchdog aborts the transfer if the device stalls.
//
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   command interface (slave side): wr_ps2, din, tx_idle,
//         tx_done_tick, tx_err, state_dbg
//   ps2c  PS/2 clock, open-drain (driven 0 or released)
//   ps2d  PS/2 data, open-drain (driven 0 or released)
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic         clk,
    input  logic         rst,
    ps2_host_tx_if.slave bus,
    inout  wire          ps2c,
    inout  wire          ps2d
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FLT_W = $clog2(FILTER_LEN + 1);

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RTS       = 3'd1,
        S_START     = 3'd2,
        S_DATA      = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Line synchronisers and clock filter
    // ------------------------------------------------------------------
    logic             c_s1, c_s2;
    logic             d_s1, d_s2;
    logic             fc;
    logic [FLT_W-1:0] flt_cnt;
    logic             fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            c_s1    <= 1'b1;
            c_s2    <= 1'b1;
            d_s1    <= 1'b1;
            d_s2    <= 1'b1;
            fc      <= 1'b1;
            flt_cnt <= '0;
            fall    <= 1'b0;
        end else begin
            c_s1 <= ps2c;
            c_s2 <= c_s1;
            d_s1 <= ps2d;
            d_s2 <= d_s1;
            fall <= 1'b0;
            // flt_cnt counts consecutive samples that disagree with fc; the
            // FILTER_LEN-th such sample flips fc.
            if (c_s2 == fc) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_LAST) begin
                fc      <= c_s2;
                flt_cnt <= '0;
                fall    <= fc;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transfer FSM
    // ------------------------------------------------------------------
    state_t           state, nxt_state;
    logic [INH_W-1:0] inh_cnt, nxt_inh_cnt;
    logic [WD_W-1:0]  wd_cnt, nxt_wd_cnt;
    logic [3:0]       bit_cnt, nxt_bit_cnt;
    logic [8:0]       frame, nxt_frame;
    logic             ack, nxt_ack;
    logic             c_low, nxt_c_low;
    logic             d_low, nxt_d_low;
    logic             idle_q, nxt_idle;
    logic             done_q, nxt_done;
    logic             err_q, nxt_err;
    logic             active;
    logic             timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            inh_cnt <= '0;
            wd_cnt  <= '0;
            bit_cnt <= '0;
            frame   <= '0;
            ack     <= 1'b0;
            c_low   <= 1'b0;
            d_low   <= 1'b0;
            idle_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= nxt_state;
            inh_cnt <= nxt_inh_cnt;
            wd_cnt  <= nxt_wd_cnt;
            bit_cnt <= nxt_bit_cnt;
            frame   <= nxt_frame;
            ack     <= nxt_ack;
            c_low   <= nxt_c_low;
            d_low   <= nxt_d_low;
            idle_q  <= nxt_idle;
            done_q  <= nxt_done;
            err_q   <= nxt_err;
        end
    end

    assign active  = (state == S_START) || (state == S_DATA) ||
                     (state == S_STOP)  || (state == S_WAIT_IDLE);
    assign timeout = active && (wd_cnt == WD_LAST);

    always_comb begin
        nxt_state   = state;
        nxt_inh_cnt = inh_cnt;
        nxt_wd_cnt  = wd_cnt;
        nxt_bit_cnt = bit_cnt;
        nxt_frame   = frame;
        nxt_ack     = ack;
        nxt_d_low   = d_low;
        nxt_done    = 1'b0;
        nxt_err     = 1'b0;

        if (timeout) begin
            // The watchdog wins over any fall in the same cycle.
            nxt_state = S_IDLE;
            nxt_err   = 1'b1;
        end else begin
            if (active) begin
                nxt_wd_cnt = wd_cnt + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (bus.wr_ps2) begin
                        nxt_frame   = {~^bus.din, bus.din};
                        nxt_inh_cnt = '0;
                        nxt_bit_cnt = '0;
                        nxt_state   = S_RTS;
                    end
                end
                S_RTS: begin
                    if (inh_cnt == INH_LAST) begin
                        nxt_state  = S_START;
                        nxt_wd_cnt = '0;
                        nxt_d_low  = 1'b1;
                    end else begin
                        nxt_inh_cnt = inh_cnt + 1'b1;
                    end
                end
                S_START: begin
                    if (fall) begin
                        nxt_d_low   = ~frame[0];
                        nxt_frame   = {1'b0, frame[8:1]};
                        nxt_bit_cnt = 4'd1;
                        nxt_state   = S_DATA;
                    end
                end
                S_DATA: begin
                    if (fall) begin
                        // bit_cnt==9 means parity is already on the line.
                        if (bit_cnt == 4'd9) begin
                            nxt_d_low = 1'b0;
                            nxt_state = S_STOP;
                        end else begin
                            nxt_d_low   = ~frame[0];
                            nxt_frame   = {1'b0, frame[8:1]};
                            nxt_bit_cnt = bit_cnt + 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    if (fall) begin
                        nxt_ack   = d_s2;
                        nxt_state = S_WAIT_IDLE;
                    end
                end
                S_WAIT_IDLE: begin
                    if (fc && d_s2) begin
                        nxt_done  = ~ack;
                        nxt_err   = ack;
                        nxt_state = S_IDLE;
                    end
                end
                default: begin
                    nxt_state = S_IDLE;
                end
            endcase
        end

        if ((nxt_state == S_IDLE) || (nxt_state == S_RTS)) begin
            nxt_d_low = 1'b0;
        end
        nxt_c_low = (nxt_state == S_RTS);
        nxt_idle  = (nxt_state == S_IDLE);
    end

    assign ps2c = c_low ? 1'b0 : 1'bz;
    assign ps2d = d_low ? 1'b0 : 1'bz;

    assign bus.tx_idle      = idle_q;
    assign bus.tx_done_tick = done_q;
    assign bus.tx_err       = err_q;
    assign bus.state_dbg    = state;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device on the
// bus. Expected frames come from model_frame(): start 0, data LSB-first,
// odd parity, stop 1.
module tb_ps2_host_tx;
  localparam int INH  = 1000;
  localparam int TO   = 5000;
  localparam int FILT = 8;
  localparam int HALF = 30;

  logic clk = 1'b0;
  logic rst;
  wire  ps2c;
  wire  ps2d;
  logic dev_c_low = 1'b0;
  logic dev_d_low = 1'b0;

  assign ps2c = dev_c_low ? 1'b0 : 1'bz;
  assign ps2d = dev_d_low ? 1'b0 : 1'bz;
  pullup (ps2c);
  pullup (ps2d);

  ps2_host_tx_if bus();

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .FILTER_LEN(FILT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .ps2c(ps2c),
    .ps2d(ps2d)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- pulse monitor ----------------
  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;

  always @(negedge clk) begin
    if (bus.tx_done_tick === 1'b1) done_cnt <= done_cnt + 1;
    if (bus.tx_err === 1'b1) err_cnt <= err_cnt + 1;
    if (bus.tx_done_tick === 1'b1 && bus.tx_err === 1'b1) both_cnt <= both_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  logic [10:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    ones = 0;
    f = '0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      ones += int'(b[i]);
    end
    f[9]  = (ones % 2 == 0) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic pop_exp(output logic [10:0] e);
    if (exp_q.size() == 0) e = 'x;
    else e = exp_q.pop_front();
  endtask

  // ---------------- drivers ----------------
  // Strobe wr_ps2 for one cycle; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] b);
    bus.din    = b;
    bus.wr_ps2 = 1'b1;
    @(negedge clk);
    bus.wr_ps2 = 1'b0;
  endtask

  // Count negedges with ps2c low; returns at the first negedge with ps2c high.
  task automatic wait_rts(output int len);
    len = 1;
    while (ps2c !== 1'b1 && len <= INH + 100) begin
      @(negedge clk);
      if (ps2c !== 1'b1) len++;
    end
    if (len > INH + 100) len = -1;
  endtask

  task automatic wait_idle(output bit ok);
    int k;
    k = 0;
    while (bus.tx_idle !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    ok = (bus.tx_idle === 1'b1);
  endtask

  // Device side: reads start bit, then clocks 11 falls, sampling ps2d just
  // after each rising edge; drives ACK before fall 11.
  task automatic device_frame(input bit ack, input int glitch_fall, input int wr_fall,
                              input int stop_after, output logic [10:0] got);
    got = '0;
    repeat (20) @(negedge clk);
    got[0] = ps2d;
    for (int f = 1; f <= 11; f++) begin
      if (f == 11) begin
        dev_d_low = ~ack;
        repeat (5) @(negedge clk);
      end
      dev_c_low = 1'b1;
      if (f == wr_fall) begin
        repeat (HALF / 2) @(negedge clk);
        bus.din    = 8'h00;
        bus.wr_ps2 = 1'b1;
        @(negedge clk);
        bus.wr_ps2 = 1'b0;
        repeat (HALF - HALF / 2 - 1) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      dev_c_low = 1'b0;
      @(negedge clk);
      if (f <= 10) got[f] = ps2d;
      if (f == stop_after) return;
      if (f == 11) begin
        dev_d_low = 1'b0;
      end else if (f == glitch_fall) begin
        repeat (15) @(negedge clk);
        dev_c_low = 1'b1;
        repeat (3) @(negedge clk);
        dev_c_low = 1'b0;
        repeat (HALF - 19) @(negedge clk);
      end else begin
        repeat (HALF - 1) @(negedge clk);
      end
    end
  endtask

  task automatic run_frame(input logic [7:0] b, input bit ack, input int glitch_fall,
                           input int wr_fall, output logic [10:0] got, output int rts_len,
                           output logic lat_c, output logic start_d, output bit idle_ok);
    send(b);
    lat_c = ps2c;
    wait_rts(rts_len);
    start_d = ps2d;
    device_frame(ack, glitch_fall, wr_fall, 0, got);
    wait_idle(idle_ok);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++;
    if (bus.tx_idle !== 1'b1) $display("FAIL reset_idle: got %b want 1", bus.tx_idle);
    else n_pass++;
    n_checks++;
    if (bus.tx_done_tick !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.tx_done_tick);
    else n_pass++;
    n_checks++;
    if (bus.tx_err !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.tx_err);
    else n_pass++;
    n_checks++;
    if (ps2c !== 1'b1 || ps2d !== 1'b1) $display("FAIL reset_lines: got c=%b d=%b want 1 1", ps2c, ps2d);
    else n_pass++;
  endtask

  task automatic test_enable_f4();
    logic [10:0] got, e;
    int len, d0, e0;
    logic lat_c, start_d;
    bit ok;
    d0 = done_cnt; e0 = err_cnt;
    exp_q.push_back(model_frame(8'hF4));
    run_frame(8'hF4, 1'b0, -1, -1, got, len, lat_c, start_d, ok);
    pop_exp(e);
    n_checks++;
    if (lat_c !== 1'b0) $display("FAIL f4_latency: ps2c got %b want 0 one cycle after wr", lat_c);
    else n_pass++;
    n_checks++;
    if (len != INH) $display("FAIL f4_rts_len: got %0d want %0d", len, INH);
    else n_pass++;
    n_checks++;
    if (start_d !== 1'b0) $display("FAIL f4_start_bit: got %b want 0", start_d);
    else n_pass++;
    n_checks++;
    if (got !== e) $display("FAIL f4_frame: got %b want %b", got, e);
    else n_pass++;
    n_checks++;
    if (done_cnt - d0 != 1 || err_cnt - e0 != 0)
      $display("FAIL f4_pulses: got done=%0d err=%0d want 1 0", done_cnt - d0, err_cnt - e0);
    else n_pass++;
    n_checks++;
    if (!ok) $display("FAIL f4_idle: tx_idle got %b want 1", bus.tx_idle);
    else n_pass++;
  endtask

  task automatic test_nack_ff();
    logic [10:0] got, e;
    int len, d0, e0;
    logic lat_c, start_d;
    bit ok;
    d0 = done_cnt; e0 = err_cnt;
    exp_q.push_back(model_frame(8'hFF));
    run_frame(8'hFF, 1'b1, -1, -1, got, len, lat_c, start_d, ok);
    pop_exp(e);
    n_checks++;
    if (got !== e) $display("FAIL ff_frame: got %b want %b", got, e);
    else n_pass++;
    n_checks++;
    if (done_cnt - d0 != 0 || err_cnt - e0 != 1)
      $display("FAIL ff_pulses: got done=%0d err=%0d want 0 1", done_cnt - d0, err_cnt - e0);
    else n_pass++;
    n_checks++;
    if (!ok) $display("FAIL ff_idle: tx_idle got %b want 1", bus.tx_idle);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int len, k, d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send(8'hF4);
    wait_rts(len);
    k = 0;
    while (bus.tx_err !== 1'b1 && k < TO + 100) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k != TO) $display("FAIL timeout_cycles: got %0d want %0d", k, TO);
    else n_pass++;
    n_checks++;
    if (ps2c !== 1'b1 || ps2d !== 1'b1) $display("FAIL timeout_lines: got c=%b d=%b want 1 1", ps2c, ps2d);
    else n_pass++;
    n_checks++;
    if (bus.tx_idle !== 1'b1) $display("FAIL timeout_idle: got %b want 1", bus.tx_idle);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_cnt - d0 != 0 || err_cnt - e0 != 1)
      $display("FAIL timeout_pulses: got done=%0d err=%0d want 0 1", done_cnt - d0, err_cnt - e0);
    else n_pass++;
  endtask

  task automatic test_ignore_wr();
    logic [10:0] got, e;
    int len, d0;
    logic lat_c, start_d;
    bit ok;
    d0 = done_cnt;
    exp_q.push_back(model_frame(8'hF4));
    run_frame(8'hF4, 1'b0, -1, 5, got, len, lat_c, start_d, ok);
    pop_exp(e);
    n_checks++;
    if (got !== e) $display("FAIL ignore_frame: got %b want %b", got, e);
    else n_pass++;
    n_checks++;
    if (done_cnt - d0 != 1) $display("FAIL ignore_done: got %0d want 1", done_cnt - d0);
    else n_pass++;
    repeat (50) @(negedge clk);
    n_checks++;
    if (ps2c !== 1'b1 || bus.tx_idle !== 1'b1)
      $display("FAIL ignore_no_restart: got c=%b idle=%b want 1 1", ps2c, bus.tx_idle);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [10:0] got, e;
    int len, d0, e0;
    logic lat_c, start_d;
    bit ok;
    d0 = done_cnt; e0 = err_cnt;
    send(8'hE5);
    wait_rts(len);
    device_frame(1'b0, -1, -1, 5, got);
    n_checks++;
    if (ps2d !== 1'b0) $display("FAIL rstmid_d4_driven: got %b want 0", ps2d);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ps2c !== 1'b1 || ps2d !== 1'b1) $display("FAIL rstmid_lines: got c=%b d=%b want 1 1", ps2c, ps2d);
    else n_pass++;
    n_checks++;
    if (bus.tx_idle !== 1'b1) $display("FAIL rstmid_idle: got %b want 1", bus.tx_idle);
    else n_pass++;
    rst = 1'b0;
    repeat (50) @(negedge clk);
    n_checks++;
    if (done_cnt - d0 != 0 || err_cnt - e0 != 0)
      $display("FAIL rstmid_pulses: got done=%0d err=%0d want 0 0", done_cnt - d0, err_cnt - e0);
    else n_pass++;
    d0 = done_cnt;
    exp_q.push_back(model_frame(8'hF3));
    run_frame(8'hF3, 1'b0, -1, -1, got, len, lat_c, start_d, ok);
    pop_exp(e);
    n_checks++;
    if (got !== e || len != INH) $display("FAIL rstmid_f3_frame: got %b len %0d want %b len %0d", got, len, e, INH);
    else n_pass++;
    n_checks++;
    if (done_cnt - d0 != 1) $display("FAIL rstmid_f3_done: got %0d want 1", done_cnt - d0);
    else n_pass++;
  endtask

  task automatic test_glitch();
    logic [10:0] got, e;
    int len, d0, e0;
    logic lat_c, start_d;
    bit ok;
    d0 = done_cnt; e0 = err_cnt;
    exp_q.push_back(model_frame(8'hF4));
    run_frame(8'hF4, 1'b0, 4, -1, got, len, lat_c, start_d, ok);
    pop_exp(e);
    n_checks++;
    if (got !== e) $display("FAIL glitch_frame: got %b want %b", got, e);
    else n_pass++;
    n_checks++;
    if (done_cnt - d0 != 1 || err_cnt - e0 != 0)
      $display("FAIL glitch_pulses: got done=%0d err=%0d want 1 0", done_cnt - d0, err_cnt - e0);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [10:0] got, e;
    logic [7:0] a, b;
    int len, d0, idle_n, k;
    bit ok;
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    d0 = done_cnt;
    exp_q.push_back(model_frame(a));
    exp_q.push_back(model_frame(b));
    send(a);
    wait_rts(len);
    device_frame(1'b0, -1, -1, 0, got);
    pop_exp(e);
    n_checks++;
    if (got !== e) $display("FAIL b2b_first_frame: got %b want %b", got, e);
    else n_pass++;
    // Hold wr_ps2 from inside WAIT_IDLE: the return-to-idle cycle must not
    // accept it, the following one must.
    bus.din    = b;
    bus.wr_ps2 = 1'b1;
    idle_n = 0;
    k = 0;
    while (k < 300) begin
      @(negedge clk);
      k++;
      if (bus.tx_idle === 1'b1) idle_n++;
      else if (idle_n > 0) break;
    end
    bus.wr_ps2 = 1'b0;
    n_checks++;
    if (idle_n != 1) $display("FAIL b2b_idle_cycles: got %0d want 1", idle_n);
    else n_pass++;
    n_checks++;
    if (ps2c !== 1'b0) $display("FAIL b2b_rts_start: ps2c got %b want 0", ps2c);
    else n_pass++;
    wait_rts(len);
    len = len + 1;
    device_frame(1'b0, -1, -1, 0, got);
    wait_idle(ok);
    repeat (3) @(negedge clk);
    pop_exp(e);
    n_checks++;
    if (got !== e) $display("FAIL b2b_second_frame: got %b want %b", got, e);
    else n_pass++;
    n_checks++;
    if (done_cnt - d0 != 2) $display("FAIL b2b_done: got %0d want 2", done_cnt - d0);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [10:0] got, e;
    logic [7:0] b;
    bit ack, ok;
    int len, d0, e0;
    logic lat_c, start_d;
    for (int i = 0; i < 3; i++) begin
      b   = 8'($urandom_range(0, 255));
      ack = 1'($urandom_range(0, 1));
      d0 = done_cnt; e0 = err_cnt;
      exp_q.push_back(model_frame(b));
      run_frame(b, ack, -1, -1, got, len, lat_c, start_d, ok);
      pop_exp(e);
      n_checks++;
      if (got !== e) $display("FAIL rand_frame byte=%h: got %b want %b", b, got, e);
      else n_pass++;
      n_checks++;
      if (done_cnt - d0 != (ack ? 0 : 1) || err_cnt - e0 != (ack ? 1 : 0))
        $display("FAIL rand_pulses byte=%h ack=%0d: got done=%0d err=%0d", b, ack, done_cnt - d0, err_cnt - e0);
      else n_pass++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.wr_ps2 = 1'b0;
    bus.din    = 8'h00;
    rst        = 1'b1;
    test_reset();
    test_enable_f4();
    test_nack_ff();
    test_timeout();
    test_ignore_wr();
    test_reset_mid();
    test_glitch();
    test_back_to_back();
    test_random();
    n_checks++;
    if (both_cnt != 0) $display("FAIL done_err_overlap: got %0d cycles want 0", both_cnt);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends one command byte (e.g. 0xF4 "enable data reporting", 0xFF reset) to the mouse over the shared ps2c/ps2d open-drain lines. It implements the host request-to-send sequence, serialises 8 data bits LSB-first plus odd parity on device-generated clock edges, releases the line for the stop bit and checks the device ACK. It sits beside the mouse receive path; `tx_idle` gates that receiver while a command is in flight.

Parameters:
- INHIBIT_CYCLES, 10000, clk cycles ps2c is held low for request-to-send (100 us at 100 MHz).
- TIMEOUT_CYCLES, 2000000, watchdog limit from clock release to ACK/idle (20 ms at 100 MHz).
- FILTER_LEN, 8, consecutive equal ps2c samples needed to change the filtered clock.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  synchronous, active-high reset.
- wr_ps2  in  1  start strobe; accepted only when tx_idle=1.
- din  in  8  command byte, captured on the accepted wr_ps2 cycle.
- ps2c  inout  1  PS/2 clock, open-drain: driven 0 or Z, never 1.
- ps2d  inout  1  PS/2 data, open-drain: driven 0 or Z, never 1.
- tx_idle  out  1  1 when no transfer is active.
- tx_done_tick  out  1  one-cycle pulse: byte sent and ACK=0 received.
- tx_err  out  1  one-cycle pulse: NACK (ACK=1) or watchdog timeout.

Behaviour:
- Line sampling: ps2c and ps2d each pass through a 2-FF synchroniser.
  - Filtered clock fc goes 0 after FILTER_LEN consecutive 0 samples and 1 after FILTER_LEN consecutive 1 samples; otherwise it holds.
  - fall = fc goes 1->0, registered, one cycle wide.
- Reset (synchronous): state=IDLE, both lines Z, tx_idle=1, tx_done_tick=0, tx_err=0, counters=0, fc=1.
  - Reset asserted mid-frame releases both lines on the next clk edge.
- Frame register: 9 bits {par, din}, with par = ~^din (odd parity). Bit counter is 4 bits.
- FSM:
  - IDLE: lines Z, tx_idle=1. On wr_ps2, latch din, go to RTS, reset the counter; tx_idle=0 from the next cycle.
  - RTS: drive ps2c=0, ps2d=Z for exactly INHIBIT_CYCLES cycles, then go to START.
  - START: release ps2c (Z), drive ps2d=0 (start bit), start the watchdog.
    - On fall: put frame bit0 on ps2d (bit 0 drives 0, bit 1 gives Z); go to DATA with bit count 1.
  - DATA: on each fall, present the next frame bit. After the parity bit has been presented, the next fall releases ps2d and goes to STOP.
    - So falls #1..#9 present d0..d7 then par; fall #10 releases ps2d.
  - STOP: on fall #11, sample synchronised ps2d as the ACK bit and go to WAIT_IDLE.
  - WAIT_IDLE: wait until fc=1 and synchronised ps2d=1, then go to IDLE.
    - If ACK=0, pulse tx_done_tick; if ACK=1, pulse tx_err.
- Watchdog: counts from START entry. If it reaches TIMEOUT_CYCLES in START, DATA, STOP or WAIT_IDLE:
  - release both lines, pulse tx_err, go to IDLE.
  - A timeout preempts a fall in the same cycle.
- wr_ps2 while tx_idle=0 is ignored: no re-latch, no restart.
- wr_ps2 in the same cycle the FSM returns to IDLE is ignored; it is accepted from the next cycle.
- tx_done_tick and tx_err are never asserted together.
- Latency: wr_ps2 to ps2c low is 1 cycle. RTS duration is exactly INHIBIT_CYCLES cycles.

Test Plan:
- Send 0xF4 (par=0) with a device model clocking at 12.5 kHz, ACK=0:
  - ps2c held low exactly 10000 cycles;
  - device samples 0, then 0,0,1,0,1,1,1,1, par 0, stop 1 on rising edges;
  - one tx_done_tick; tx_idle returns to 1.
- Send 0xFF (par=1) with the device driving ACK=1 -> data bits all 1, parity 1, tx_err pulses once, no tx_done_tick.
- Device never clocks after RTS -> tx_err exactly TIMEOUT_CYCLES cycles after START entry; both lines Z; tx_idle=1.
- wr_ps2 with din=0x00 during bit 4 of a 0xF4 frame -> ignored; 0xF4 completes unchanged.
- rst asserted after fall #5 -> both lines Z next cycle, tx_idle=1, no pulses. A following 0xF3 frame sends correctly.
- Glitch: 3-cycle low pulse on ps2c during DATA -> no bit advance (FILTER_LEN=8); the frame completes correctly.
